exec_profiler: RTL and testbench

Hardware execution-window profiler that sits beside the Mini-RISC-V core inside rv_uart_top and consumes the IF/ID stage's present address and branch strobe. It counts clock cycles between a programmable start address being fetched and a programmable stop address being reached through a taken branch. Software or a bench configures and reads it through a small word-addressed register port. It is the on-chip counterpart of the cycle-time measurements used to compare RAS-enabled and RAS-disabled runs.

---
 rtl/exec_profiler_pkg.sv | 21 ++
 rtl/prof_sat_counter.sv | 30 +++
 rtl/exec_profiler.sv | 134 +++++++++++++
 tb/tb_exec_profiler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_profiler_pkg.sv
// Shared definitions for the execution-window profiler: FSM states, register
// word offsets, CTRL/STATUS bit positions and default widths.
package exec_profiler_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_COUNT, ST_DONE} state_e;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_START    = 3'd1;
  localparam logic [2:0] OFF_STOP     = 3'd2;
  localparam logic [2:0] OFF_CYCLES   = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;
  localparam logic [2:0] OFF_BRANCHES = 3'd5;

  localparam int CTRL_ARM  = 0;
  localparam int CTRL_CLR  = 1;
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVF  = 2;
endpackage

// File: rtl/prof_sat_counter.sv
// Saturating up-counter; sat_o flags an increment lost because the count is
// already all-ones. clr_i has priority over inc_i.
module prof_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             Rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_max;

  assign at_max = &cnt_q;
  assign sat_o  = inc_i & at_max & ~clr_i;
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                cnt_d = '0;
    else if (inc_i && !at_max) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/exec_profiler.sv
// Cycle-window profiler: counts cycles from a START_ADDR fetch to a taken
// branch at STOP_ADDR. Define EXEC_PROFILER_BRANCH_CNT_EN to add BRANCHES.
module exec_profiler
  import exec_profiler_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              branch,
  input  logic              flush,
  input  logic              cfg_wen,
  input  logic              cfg_ren,
  input  logic [4:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  output logic              busy,
  output logic              done
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] start_q, stop_q;
  logic              done_flag_q, done_flag_d, ovf_q, ovf_d, done_q;
  logic [31:0]       rdata_q, rd_val;
  logic [2:0]        word;
  logic              wr_ctrl, arm_wr, clr_wr, cfg_ok, start_hit, stop_hit;
  logic              cnt_clr, cyc_inc, set_done, cyc_sat, br_sat;
  logic [CNT_W-1:0]  cyc_cnt, br_cnt;
  logic              unused_addr_lsb;

  assign word            = cfg_addr[4:2];
  assign unused_addr_lsb = ^cfg_addr[1:0];
  assign wr_ctrl   = cfg_wen && (word == OFF_CTRL);
  assign arm_wr    = wr_ctrl & cfg_wdata[CTRL_ARM];
  assign clr_wr    = wr_ctrl & cfg_wdata[CTRL_CLR];
  assign cfg_ok    = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign start_hit = (pc_addr == start_q) & ~flush;
  assign stop_hit  = (pc_addr == stop_q) & branch & ~flush;

  // Increment on the start-hit edge too, so the final count equals the
  // stop-hit index minus the start-hit index.
  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cyc_inc  = 1'b0;
    set_done = 1'b0;
    if (clr_wr) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (arm_wr) begin
          state_d = ST_ARMED;
          cnt_clr = 1'b1;
        end
        ST_ARMED: if (start_hit) begin
          state_d = ST_COUNT;
          cyc_inc = 1'b1;
        end
        ST_COUNT: if (stop_hit) begin
          state_d  = ST_DONE;
          set_done = 1'b1;
        end else begin
          cyc_inc = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    done_flag_d = done_flag_q | set_done;
    ovf_d       = ovf_q | cyc_sat | br_sat;
    if (cnt_clr) begin
      done_flag_d = 1'b0;
      ovf_d       = 1'b0;
    end
  end

  prof_sat_counter #(.CNT_W(CNT_W)) u_cyc (
    .clk(clk), .Rst_n(Rst_n), .clr_i(cnt_clr), .inc_i(cyc_inc),
    .cnt_o(cyc_cnt), .sat_o(cyc_sat)
  );

`ifdef EXEC_PROFILER_BRANCH_CNT_EN
  logic br_inc;
  assign br_inc = (state_q == ST_COUNT) & branch & ~flush & ~stop_hit;
  prof_sat_counter #(.CNT_W(CNT_W)) u_br (
    .clk(clk), .Rst_n(Rst_n), .clr_i(cnt_clr), .inc_i(br_inc),
    .cnt_o(br_cnt), .sat_o(br_sat)
  );
`else
  assign br_cnt = '0;
  assign br_sat = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    case (word)
      OFF_START:    rd_val = 32'(start_q);
      OFF_STOP:     rd_val = 32'(stop_q);
      OFF_CYCLES:   rd_val = 32'(cyc_cnt);
      OFF_STATUS:   rd_val = {29'd0, ovf_q, done_flag_q, busy};
      OFF_BRANCHES: rd_val = 32'(br_cnt);
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      start_q     <= '0;
      stop_q      <= '0;
      done_flag_q <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      done_flag_q <= done_flag_d;
      ovf_q       <= ovf_d;
      done_q      <= set_done;
      if (cfg_ren) rdata_q <= rd_val;
      // Address writes are judged against the state before this edge.
      if (cfg_wen && cfg_ok && word == OFF_START) start_q <= ADDR_W'(cfg_wdata);
      if (cfg_wen && cfg_ok && word == OFF_STOP)  stop_q  <= ADDR_W'(cfg_wdata);
    end
  end

  assign busy      = (state_q == ST_ARMED) || (state_q == ST_COUNT);
  assign done      = done_q;
  assign cfg_rdata = rdata_q;
endmodule

// File: tb/tb_exec_profiler.sv
// Scoreboarded bench for exec_profiler: register reads push expectations that
// a monitor pops when cfg_rdata updates; busy/done are checked inline.
module tb_exec_profiler;
  localparam int CW = 8;
  localparam logic [31:0] IDLE_PC = 32'h1000;
`ifdef EXEC_PROFILER_BRANCH_CNT_EN
  localparam logic [31:0] EXP_BR = 32'd7;
`else
  localparam logic [31:0] EXP_BR = 32'd0;
`endif

  logic        clk = 1'b0, Rst_n = 1'b0;
  logic [31:0] pc_addr = IDLE_PC;
  logic        branch = 1'b0, flush = 1'b0, cfg_wen = 1'b0, cfg_ren = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0, cfg_rdata;
  logic        busy, done;

  int checks = 0, failures = 0;

  typedef struct { string name; logic [31:0] exp; } rd_exp_t;
  rd_exp_t sb[$];
  rd_exp_t mon_e;

  always #5 clk = ~clk;

  exec_profiler #(.ADDR_W(32), .CNT_W(CW)) dut (
    .clk(clk), .Rst_n(Rst_n), .pc_addr(pc_addr), .branch(branch), .flush(flush),
    .cfg_wen(cfg_wen), .cfg_ren(cfg_ren), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .busy(busy), .done(done)
  );

  // Read-data monitor: cfg_rdata is valid just after the edge that saw cfg_ren.
  always @(posedge clk) begin
    if (cfg_ren === 1'b1 && Rst_n === 1'b1) begin
      #1;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: got %h, no expectation queued", cfg_rdata);
      end else begin
        mon_e = sb.pop_front();
        if (cfg_rdata !== mon_e.exp) begin
          failures++;
          $display("FAIL %s: got %h expected %h", mon_e.name, cfg_rdata, mon_e.exp);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [2:0] w, input logic [31:0] d);
    cfg_wen = 1'b1; cfg_addr = {w, 2'b00}; cfg_wdata = d;
    tick();
    cfg_wen = 1'b0;
  endtask

  task automatic rd(input logic [2:0] w, input logic [31:0] exp, input string nm);
    sb.push_back('{nm, exp});
    cfg_ren = 1'b1; cfg_addr = {w, 2'b00};
    tick();
    cfg_ren = 1'b0;
  endtask

  task automatic pcyc(input logic [31:0] a, input logic b, input logic f, input int n);
    pc_addr = a; branch = b; flush = f;
    tick(n);
    pc_addr = IDLE_PC; branch = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    tick(2);
    checks++;
    if ({cfg_rdata, busy, done} !== 34'd0) begin
      failures++;
      $display("FAIL rst_outputs: got rdata=%h busy=%b done=%b expected all 0", cfg_rdata, busy, done);
    end
    Rst_n = 1'b1;
    tick();
    rd(3'd1, 32'h0, "rst_start");
    rd(3'd2, 32'h0, "rst_stop");
    rd(3'd3, 32'h0, "rst_cycles");
    rd(3'd4, 32'h0, "rst_status");
    rd(3'd7, 32'h0, "rst_unmapped");
  endtask

  task automatic test_basic();
    wr(3'd1, 32'h0);
    wr(3'd2, 32'h14);
    wr(3'd0, 32'h1);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_rise: got %b expected 1", busy); end
    tick(5);
    pcyc(32'h0, 1'b0, 1'b0, 1);
    tick(99);
    pcyc(32'h14, 1'b1, 1'b0, 1);
    checks++;
    if ({done, busy} !== 2'b10) begin
      failures++; $display("FAIL basic_done_pulse: got done=%b busy=%b expected done=1 busy=0", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL basic_done_width: got %b expected 0", done); end
    rd(3'd3, 32'd100, "basic_cycles");
    rd(3'd4, 32'h2, "basic_status");
  endtask

  task automatic test_filter();
    wr(3'd1, 32'h40);
    wr(3'd2, 32'h80);
    wr(3'd0, 32'h1);
    pcyc(32'h40, 1'b0, 1'b1, 1);
    rd(3'd3, 32'd0, "filt_flushed_start");
    pcyc(32'h40, 1'b0, 1'b0, 1);   // H
    pcyc(32'h80, 1'b0, 1'b0, 1);   // H+1 stop without branch
    pcyc(32'h80, 1'b1, 1'b1, 1);   // H+2 flushed stop
    pcyc(32'h40, 1'b0, 1'b0, 1);   // H+3 repeated start
    wr(3'd1, 32'hDEAD);            // H+4 ignored while counting
    tick(5);                       // H+5..H+9
    rd(3'd3, 32'd10, "filt_live_cycles"); // H+10
    tick();                        // H+11
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL filt_busy: got %b expected 1", busy); end
    pcyc(32'h80, 1'b1, 1'b0, 1);   // H+12
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL filt_done: got %b expected 1", done); end
    rd(3'd3, 32'd12, "filt_cycles");
    rd(3'd1, 32'h40, "filt_start_locked");
  endtask

  task automatic test_saturation();
    wr(3'd1, 32'h0);
    wr(3'd2, 32'h14);
    wr(3'd0, 32'h1);
    pcyc(32'h0, 1'b0, 1'b0, 1);
    tick(299);
    pcyc(32'h14, 1'b1, 1'b0, 1);
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL sat_done: got %b expected 1", done); end
    rd(3'd3, 32'hFF, "sat_cycles");
    rd(3'd4, 32'h6, "sat_status");
  endtask

  task automatic test_clear();
    wr(3'd0, 32'h1);
    pcyc(32'h0, 1'b0, 1'b0, 1);
    tick(49);
    wr(3'd0, 32'h2);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++; $display("FAIL clr_busy_done: got busy=%b done=%b expected 0 0", busy, done);
    end
    pcyc(32'h14, 1'b1, 1'b0, 1);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL clr_no_done: got %b expected 0", done); end
    rd(3'd3, 32'd0, "clr_cycles");
    rd(3'd4, 32'h0, "clr_status");
  endtask

  task automatic test_reset_mid();
    wr(3'd1, 32'h40);
    wr(3'd2, 32'h80);
    wr(3'd0, 32'h1);
    pcyc(32'h40, 1'b0, 1'b0, 1);
    tick(20);
    rd(3'd3, 32'd21, "rstm_live_cycles");
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if ({cfg_rdata, busy, done} !== 34'd0) begin
      failures++;
      $display("FAIL rstm_outputs: got rdata=%h busy=%b done=%b expected all 0", cfg_rdata, busy, done);
    end
    tick(2);
    Rst_n = 1'b1;
    tick();
    rd(3'd1, 32'h0, "rstm_start_cleared");
    wr(3'd1, 32'h40);
    wr(3'd2, 32'h80);
    wr(3'd0, 32'h1);
    pcyc(32'h40, 1'b0, 1'b0, 1);
    tick(29);
    pcyc(32'h80, 1'b1, 1'b0, 1);
    rd(3'd3, 32'd30, "rstm_cycles");
    rd(3'd4, 32'h2, "rstm_status");
  endtask

  task automatic test_branches();
    wr(3'd1, 32'h300);
    wr(3'd2, 32'h304);
    wr(3'd0, 32'h1);
    pcyc(32'h300, 1'b0, 1'b0, 1);
    for (int i = 0; i < 20; i++) pcyc(IDLE_PC, (i % 3) == 0, 1'b0, 1);
    pcyc(IDLE_PC, 1'b1, 1'b1, 1);
    pcyc(32'h304, 1'b1, 1'b0, 1);
    rd(3'd5, EXP_BR, "br_count");
    rd(3'd3, 32'd22, "br_cycles");
  endtask

  task automatic test_back_to_back();
    wr(3'd1, 32'h200);
    wr(3'd2, 32'h200);
    wr(3'd0, 32'h1);
    pcyc(32'h200, 1'b1, 1'b0, 1);
    tick();
    checks++;
    if ({busy, done} !== 2'b10) begin
      failures++; $display("FAIL b2b_start_wins: got busy=%b done=%b expected 1 0", busy, done);
    end
    pcyc(32'h200, 1'b1, 1'b0, 1);
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL b2b_done: got %b expected 1", done); end
    rd(3'd3, 32'd2, "b2b_cycles");
    wr(3'd0, 32'h1);
    rd(3'd3, 32'd0, "b2b_rearm_cycles");
    rd(3'd4, 32'h1, "b2b_rearm_status");
    wr(3'd0, 32'h2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_filter();
    test_saturation();
    test_clear();
    test_reset_mid();
    test_branches();
    test_back_to_back();
    tick(2);
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
